// File: rtl/key_event_bank.sv
// key_event_bank: synchronise, debounce and classify N pushbutton keys into one-cycle events.
// Ports:
//   i_clk        system clock (12 MHz audio domain)
//   i_rst        synchronous active-high reset
//   i_key        raw asynchronous key inputs
//   i_mask       1 = suppress every event pulse on that channel (o_level still tracks)
//   o_level      debounced pressed-sense level (1 = pressed)
//   o_press      1-cycle pulse on accepted press
//   o_release    1-cycle pulse on accepted release
//   o_long       1-cycle pulse once a press has lasted LONG_CYCLES
//   o_repeat     1-cycle pulse every REPEAT_CYCLES after o_long
//   o_any_press  OR of o_press across channels
// Build option: define KEY_EVENT_REPEAT_EN to build the auto-repeat counter; otherwise o_repeat is tied 0.
module key_event_bank #(
    parameter int N_KEYS        = 4,
    parameter int DEB_CYCLES    = 12000,
    parameter int LONG_CYCLES   = 6000000,
    parameter int REPEAT_CYCLES = 1200000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_key,
    input  logic [N_KEYS-1:0] i_mask,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_repeat,
    output logic              o_any_press
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = LONG_CYCLES > 1 ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    logic [N_KEYS-1:0] s1, s2;

    // Two-flop synchroniser on the pressed-sense value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= i_key ^ {N_KEYS{ACTIVE_LOW}};
            s2 <= s1;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        state_t        st, st_n;
        logic          lvl, acc, ev_p, ev_r, ev_l, pr, rl, lg;
        logic [DW-1:0] dcnt;
        logic [HW-1:0] hcnt;
        // acc marks the cycle a level change is accepted; level and events update on the same edge
        assign acc = (s2[k] != lvl) && (dcnt == D_LAST);
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                lvl  <= 1'b0;
                dcnt <= '0;
            end else begin
                lvl  <= lvl ^ acc;
                dcnt <= (s2[k] == lvl || acc) ? '0 : dcnt + DW'(1);
            end
        end
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                st   <= IDLE;
                hcnt <= '0;
                pr   <= 1'b0;
                rl   <= 1'b0;
                lg   <= 1'b0;
            end else begin
                st   <= st_n;
                hcnt <= (st != PRESSED) ? '0 : (hcnt == H_LAST) ? hcnt : hcnt + HW'(1);
                pr   <= ev_p & ~i_mask[k];
                rl   <= ev_r & ~i_mask[k];
                lg   <= ev_l & ~i_mask[k];
            end
        end
        // Level is 0 exactly in IDLE, so an accepted change is a press from IDLE or a release otherwise
        always_comb begin
            st_n = st;
            ev_p = 1'b0;
            ev_r = 1'b0;
            ev_l = 1'b0;
            if (acc) begin
                st_n = lvl ? IDLE : PRESSED;
                ev_p = !lvl;
                ev_r = lvl;
            end else if (st == PRESSED && hcnt == H_LAST) begin
                st_n = HELD;
                ev_l = 1'b1;
            end
        end
        assign o_level[k]   = lvl;
        assign o_press[k]   = pr;
        assign o_release[k] = rl;
        assign o_long[k]    = lg;
`ifdef KEY_EVENT_REPEAT_EN
        logic [RW-1:0] rcnt;
        logic          rp;
        // Repeat counter sits at 0 until HELD and wraps on each pulse; release wins over a due repeat
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                rcnt <= '0;
                rp   <= 1'b0;
            end else begin
                rcnt <= (st != HELD || rcnt == R_LAST) ? '0 : rcnt + RW'(1);
                rp   <= (st == HELD) && (rcnt == R_LAST) && !acc && !i_mask[k];
            end
        end
        assign o_repeat[k] = rp;
`endif
    end

`ifndef KEY_EVENT_REPEAT_EN
    assign o_repeat = '0;
`endif
    assign o_any_press = |o_press;
endmodule

// File: tb/tb_key_event_bank.sv
// tb_key_event_bank: randomized and directed bench for key_event_bank against a timeline model.
module tb_key_event_bank;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] mask = 4'h0;
    logic [3:0] o_level, o_press, o_release, o_long, o_repeat;
    logic       o_any_press;

    int total = 0;
    int bad = 0;

    // Model: synchroniser pipeline, per-key run of disagreeing samples, press timestamps
    logic [3:0] ms1 = '0, ms2 = '0, mlvl = '0;
    logic [3:0] e_press = '0, e_rel = '0, e_long = '0, e_rep = '0;
    int run[4];
    int tp[4];
    int cyc = 0;

    key_event_bank #(
        .N_KEYS(4), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_key(key), .i_mask(mask),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_long(o_long), .o_repeat(o_repeat), .o_any_press(o_any_press)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] obs();
        return {o_level, o_press, o_release, o_long, o_repeat, o_any_press};
    endfunction

    function automatic logic [20:0] expv();
        return {mlvl, e_press, e_rel, e_long, e_rep, |e_press};
    endfunction

    // Events as a function of time: a press at tp fires long at tp+LONG and repeats every REP after
    task automatic model_edge();
        if (rst) begin
            ms1 = '0; ms2 = '0; mlvl = '0;
            e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
            for (int k = 0; k < 4; k++) run[k] = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                logic tog;
                int age;
                tog = 1'b0;
                e_press[k] = 1'b0; e_rel[k] = 1'b0; e_long[k] = 1'b0; e_rep[k] = 1'b0;
                if (ms2[k] != mlvl[k]) begin
                    run[k]++;
                    if (run[k] == DEB) begin
                        tog = 1'b1;
                        run[k] = 0;
                    end
                end else run[k] = 0;
                if (tog && !mlvl[k]) begin
                    tp[k] = cyc;
                    e_press[k] = !mask[k];
                end else if (tog) e_rel[k] = !mask[k];
                else if (mlvl[k]) begin
                    age = cyc - tp[k];
                    e_long[k] = !mask[k] && age == LONG;
                    e_rep[k] = !mask[k] && REP_EN && age > LONG && (age - LONG) % REP == 0;
                end
                if (tog) mlvl[k] = !mlvl[k];
            end
            ms2 = ms1;
            ms1 = ~key;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 4'hF; mask = 4'h0;
        repeat (3) begin
            tick();
            total++;
            if (obs() !== 21'b0) begin bad++; $display("FAIL reset got=%h exp=0", obs()); end
        end
        rst = 1'b0;
    endtask

    task automatic test_press();
        key[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL press_model i=%0d got=%h exp=%h", i, obs(), expv()); end
            total++;
            if (o_any_press !== (i == 6)) begin bad++; $display("FAIL press_any i=%0d got=%b exp=%b", i, o_any_press, i == 6); end
            total++;
            if (o_level[0] !== (i >= 6)) begin bad++; $display("FAIL press_level i=%0d got=%b exp=%b", i, o_level[0], i >= 6); end
        end
        key[0] = 1'b1;
        repeat (12) begin
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL press_rel got=%h exp=%h", obs(), expv()); end
        end
    endtask

    task automatic test_glitch();
        key[1] = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 3) key[1] = 1'b1;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL glitch_model got=%h exp=%h", obs(), expv()); end
            total++;
            if ({o_level[1], o_press[1], o_release[1]} !== 3'b0) begin bad++; $display("FAIL glitch_quiet i=%0d got=%b exp=000", i, {o_level[1], o_press[1], o_release[1]}); end
        end
        key[1] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 4) key[1] = 1'b1;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL glitch4_model got=%h exp=%h", obs(), expv()); end
            total++;
            if (o_press[1] !== (i == 6)) begin bad++; $display("FAIL glitch4_press i=%0d got=%b exp=%b", i, o_press[1], i == 6); end
        end
    endtask

    task automatic test_long_repeat();
        int long_at = -1, reps = 0, rel_at = -1;
        key[2] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (i == 51) key[2] = 1'b1;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL long_model i=%0d got=%h exp=%h", i, obs(), expv()); end
            if (o_long[2]) long_at = i;
            if (o_repeat[2]) reps++;
            if (o_release[2]) rel_at = i;
        end
        total++;
        if (long_at != 26) begin bad++; $display("FAIL long_time got=%0d exp=26", long_at); end
        total++;
        if (reps != (REP_EN ? 3 : 0)) begin bad++; $display("FAIL repeat_count got=%0d exp=%0d", reps, REP_EN ? 3 : 0); end
        total++;
        if (rel_at != 57) begin bad++; $display("FAIL long_release got=%0d exp=57", rel_at); end
    endtask

    task automatic test_release_race();
        int longs = 0, rel_at = -1;
        key[3] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 20) key[3] = 1'b1;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL race_model i=%0d got=%h exp=%h", i, obs(), expv()); end
            if (o_long[3]) longs++;
            if (o_release[3]) rel_at = i;
        end
        total++;
        if (longs != 0 || rel_at != 26) begin bad++; $display("FAIL race got long=%0d rel=%0d exp long=0 rel=26", longs, rel_at); end
    endtask

    task automatic test_mask();
        int first_rep = -1;
        mask = 4'b0001;
        key[0] = 1'b0;
        for (int i = 1; i <= 72; i++) begin
            tick();
            if (i == 40) mask = 4'b0000;
            if (i == 60) key[0] = 1'b1;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL mask_model i=%0d got=%h exp=%h", i, obs(), expv()); end
            total++;
            if (o_level[0] !== (i >= 6 && i < 66)) begin bad++; $display("FAIL mask_level i=%0d got=%b", i, o_level[0]); end
            if (i <= 40) begin
                total++;
                if ({o_press[0], o_long[0], o_repeat[0]} !== 3'b0) begin bad++; $display("FAIL mask_quiet i=%0d got=%b exp=000", i, {o_press[0], o_long[0], o_repeat[0]}); end
            end
            if (o_repeat[0] && first_rep < 0) first_rep = i;
        end
        total++;
        if (first_rep != (REP_EN ? 42 : -1)) begin bad++; $display("FAIL mask_phase got=%0d exp=%0d", first_rep, REP_EN ? 42 : -1); end
    endtask

    task automatic test_reset_mid();
        int reps = 0;
        key[3] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL rmid_model i=%0d got=%h exp=%h", i, obs(), expv()); end
            if (o_repeat[3]) reps++;
        end
        total++;
        if (reps != 0) begin bad++; $display("FAIL rmid_early_rep got=%0d exp=0", reps); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (obs() !== 21'b0) begin bad++; $display("FAIL rmid_reset got=%h exp=0", obs()); end
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL rmid_after i=%0d got=%h exp=%h", i, obs(), expv()); end
            total++;
            if (o_press[3] !== (i == 6)) begin bad++; $display("FAIL rmid_press i=%0d got=%b exp=%b", i, o_press[3], i == 6); end
        end
        key[3] = 1'b1;
        repeat (10) begin
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL rmid_rel got=%h exp=%h", obs(), expv()); end
        end
    endtask

    task automatic test_random();
        int left[4];
        for (int k = 0; k < 4; k++) left[k] = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 4; k++) begin
                left[k]--;
                if (left[k] <= 0) begin
                    key[k] = ~key[k];
                    left[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 8));
                end
            end
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL random i=%0d got=%h exp=%h", i, obs(), expv()); end
        end
        rst = 1'b0; key = 4'hF; mask = 4'h0;
        repeat (12) begin
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL random_settle got=%h exp=%h", obs(), expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_long_repeat();
        test_release_race();
        test_mask();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
